// File: rtl/ps2_keyb_matrix.sv
// ps2_keyb_matrix
//   Receives PS/2 keyboard frames (scan-code set 2) and maintains the 8x5 ZX
//   Spectrum keyboard matrix. It returns the active-low column state for the
//   half-rows that the ULA selects.
//
//   Optional build macro: PS2_PARITY_CHECK_EN
//     defined   - frames with bad odd parity are dropped like a bad stop bit
//     undefined - the parity bit is sampled and ignored
//
// Ports
//   clk            in   system clock (clk7 domain)
//   rst_n          in   synchronous active-low reset
//   ps2clk         in   raw PS/2 clock, asynchronous, idle high
//   ps2data        in   raw PS/2 data, asynchronous, idle high
//   rows    [7:0]  in   CPU a[15:8]; a 0 bit selects that half-row
//   kbd     [4:0]  out  column lines, active low, registered
//   scancode [7:0] out  last byte delivered by the receiver
//   scancode_valid out  one-cycle strobe when scancode updates
module ps2_keyb_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 7000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] rows,
  output logic [4:0] kbd,
  output logic [7:0] scancode,
  output logic       scancode_valid
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // One keymap entry: up to two {row, col} targets, each with a valid bit.
  typedef struct packed {
    logic       v0;
    logic [2:0] r0;
    logic [2:0] c0;
    logic       v1;
    logic [2:0] r1;
    logic [2:0] c1;
  } key_t;

  // Targets are written as octal 6'oRC: R = row, C = column.
  function automatic key_t one(input logic [5:0] rc);
    return {1'b1, rc, 7'b0};
  endfunction

  function automatic key_t two(input logic [5:0] rc0, input logic [5:0] rc1);
    return {1'b1, rc0, 1'b1, rc1};
  endfunction

  // Index is {ext, scancode}.
  function automatic key_t keymap(input logic [8:0] code);
    key_t k;
    k = '0;
    case (code)
      9'h012: k = one(6'o00); 9'h01A: k = one(6'o01); 9'h022: k = one(6'o02);
      9'h021: k = one(6'o03); 9'h02A: k = one(6'o04);
      9'h01C: k = one(6'o10); 9'h01B: k = one(6'o11); 9'h023: k = one(6'o12);
      9'h02B: k = one(6'o13); 9'h034: k = one(6'o14);
      9'h015: k = one(6'o20); 9'h01D: k = one(6'o21); 9'h024: k = one(6'o22);
      9'h02D: k = one(6'o23); 9'h02C: k = one(6'o24);
      9'h016: k = one(6'o30); 9'h01E: k = one(6'o31); 9'h026: k = one(6'o32);
      9'h025: k = one(6'o33); 9'h02E: k = one(6'o34);
      9'h045: k = one(6'o40); 9'h046: k = one(6'o41); 9'h03E: k = one(6'o42);
      9'h03D: k = one(6'o43); 9'h036: k = one(6'o44);
      9'h04D: k = one(6'o50); 9'h044: k = one(6'o51); 9'h043: k = one(6'o52);
      9'h03C: k = one(6'o53); 9'h035: k = one(6'o54);
      9'h05A: k = one(6'o60); 9'h04B: k = one(6'o61); 9'h042: k = one(6'o62);
      9'h03B: k = one(6'o63); 9'h033: k = one(6'o64);
      9'h029: k = one(6'o70); 9'h059: k = one(6'o71); 9'h03A: k = one(6'o72);
      9'h031: k = one(6'o73); 9'h032: k = one(6'o74);
      9'h066: k = two(6'o00, 6'o40);   // Backspace = CAPS + 0
      9'h16B: k = two(6'o00, 6'o34);   // Left  = CAPS + 5
      9'h172: k = two(6'o00, 6'o44);   // Down  = CAPS + 6
      9'h175: k = two(6'o00, 6'o43);   // Up    = CAPS + 7
      9'h174: k = two(6'o00, 6'o42);   // Right = CAPS + 8
      default: k = '0;
    endcase
    return k;
  endfunction

  logic           clk_s1, clk_s2, dat_s1, dat_s2, clk_f;
  logic [FW-1:0]  flt_cnt;
  logic           fall;
  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic [TW-1:0]  to_cnt;
  logic           frame_ok;
  logic           vld_p0;
  logic [7:0]     byte_p0;
  logic           brk, ext;
  logic [2:0]     skip;
  logic           vld_p1, map_p1, clr_p1, mk_p1;
  logic [7:0]     byte_p1;
  key_t           ent_p1;
  logic [7:0][4:0] matrix;
  logic [4:0]     col_any;

  // Synchronizers and clock glitch filter. The filtered clock only follows
  // the synchronized clock after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2data;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Single-cycle pulse in the cycle the filtered clock goes high -> low.
  assign fall = clk_f && !clk_s2 && (flt_cnt == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clk) begin
    if (fall && state == PARITY) par_bit <= dat_s2;
  end
  assign frame_ok = dat_s2 && (^{shreg, par_bit});
`else
  assign frame_ok = dat_s2;
`endif

  // Receiver FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!dat_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            vld_p0 <= frame_ok;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state == DATA) shreg   <= {dat_s2, shreg[7:1]};
    if (fall && state == STOP) byte_p0 <= shreg;
  end

  // Stage p1: prefix handling and keymap ROM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brk    <= 1'b0;
      ext    <= 1'b0;
      skip   <= '0;
      vld_p1 <= 1'b0;
      map_p1 <= 1'b0;
      clr_p1 <= 1'b0;
      mk_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      map_p1 <= 1'b0;
      clr_p1 <= 1'b0;
      if (vld_p0) begin
        if (skip != 3'd0) begin
          skip <= skip - 1'b1;
          brk  <= 1'b0;
          ext  <= 1'b0;
        end else begin
          case (byte_p0)
            8'hF0: brk <= 1'b1;
            8'hE0: ext <= 1'b1;
            8'hE1: begin
              skip <= 3'd7;
              brk  <= 1'b0;
              ext  <= 1'b0;
            end
            default: begin
              // BAT completion / hot-plug codes wipe the matrix, but only
              // when they are not the tail of a break sequence.
              if (!brk && (byte_p0 == 8'hAA || byte_p0 == 8'hFC)) begin
                clr_p1 <= 1'b1;
              end else begin
                map_p1 <= 1'b1;
                mk_p1  <= !brk;
              end
              brk <= 1'b0;
              ext <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    byte_p1 <= byte_p0;
    ent_p1  <= keymap({ext, byte_p0});
  end

  // Stage p2: matrix write and scancode strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix         <= '0;
      scancode       <= 8'h00;
      scancode_valid <= 1'b0;
    end else begin
      scancode_valid <= vld_p1;
      if (vld_p1) scancode <= byte_p1;
      if (clr_p1) begin
        matrix <= '0;
      end else if (map_p1) begin
        if (ent_p1.v0) matrix[ent_p1.r0][ent_p1.c0] <= mk_p1;
        if (ent_p1.v1) matrix[ent_p1.r1][ent_p1.c1] <= mk_p1;
      end
    end
  end

  // Column readout: OR of every selected half-row, inverted to active low.
  always_comb begin
    col_any = '0;
    for (int i = 0; i < 8; i++) begin
      if (!rows[i]) col_any = col_any | matrix[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) kbd <= 5'b11111;
    else        kbd <= ~col_any;
  end

endmodule

// File: tb/tb_ps2_keyb_matrix.sv
// Directed testbench for ps2_keyb_matrix: PS/2 frames are bit-banged on
// ps2clk/ps2data and the column lines are compared with hand-derived values.
module tb_ps2_keyb_matrix;

  localparam int HALF = 20;
  localparam int TO   = 7000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rows = 8'hFF;
  logic [4:0] kbd;
  logic [7:0] scancode;
  logic       scancode_valid;

  int n_cmp = 0;
  int n_fail = 0;
  int strobes = 0;
  logic [7:0] last_sc = 8'h00;

  ps2_keyb_matrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2data(ps2data),
    .rows(rows), .kbd(kbd), .scancode(scancode), .scancode_valid(scancode_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scancode_valid) begin
      strobes = strobes + 1;
      last_sc = scancode;
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2data = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      ps2clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ps2clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input int glitch_at = -1);
    send_bit(1'b0, glitch_at == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_at == i + 1);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic set_rows(input logic [7:0] r);
    @(negedge clk);
    rows = r;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL reset_kbd got=%b want=%b", kbd, 5'b11111); end
    n_cmp++; if (scancode !== 8'h00) begin n_fail++; $display("FAIL reset_scancode got=%h want=%h", scancode, 8'h00); end
    n_cmp++; if (scancode_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", scancode_valid); end
    rst_n = 1'b1;
    set_rows(8'h00);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL reset_rows00 got=%b want=%b", kbd, 5'b11111); end
  endtask

  task automatic test_make_break;
    int s0;
    s0 = strobes;
    set_rows(8'hFD);
    send_frame(8'h1C);
    n_cmp++; if (strobes !== s0 + 1) begin n_fail++; $display("FAIL make_strobes got=%0d want=%0d", strobes - s0, 1); end
    n_cmp++; if (last_sc !== 8'h1C) begin n_fail++; $display("FAIL make_scancode got=%h want=%h", last_sc, 8'h1C); end
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL make_A got=%b want=%b", kbd, 5'b11110); end
    set_rows(8'hFF);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL rows_ff got=%b want=%b", kbd, 5'b11111); end
    set_rows(8'hFD);
    send_frame(8'hF0);
    send_frame(8'h1C);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL break_A got=%b want=%b", kbd, 5'b11111); end
    n_cmp++; if (strobes !== s0 + 3) begin n_fail++; $display("FAIL break_strobes got=%0d want=%0d", strobes - s0, 3); end
  endtask

  task automatic test_backspace;
    set_rows(8'hEE);
    send_frame(8'h66);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL bksp_rowsEE got=%b want=%b", kbd, 5'b11110); end
    set_rows(8'hFE);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL bksp_caps got=%b want=%b", kbd, 5'b11110); end
    set_rows(8'hEF);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL bksp_zero got=%b want=%b", kbd, 5'b11110); end
    set_rows(8'hF7);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL bksp_row3 got=%b want=%b", kbd, 5'b11111); end
    send_frame(8'hF0);
    send_frame(8'h66);
    set_rows(8'hEE);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL bksp_release got=%b want=%b", kbd, 5'b11111); end
  endtask

  task automatic test_parity;
    int s0;
    s0 = strobes;
    set_rows(8'hFB);
    send_frame(8'h15, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    n_cmp++; if (strobes !== s0) begin n_fail++; $display("FAIL badpar_strobes got=%0d want=%0d", strobes - s0, 0); end
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL badpar_kbd got=%b want=%b", kbd, 5'b11111); end
`else
    n_cmp++; if (strobes !== s0 + 1) begin n_fail++; $display("FAIL badpar_strobes got=%0d want=%0d", strobes - s0, 1); end
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL badpar_kbd got=%b want=%b", kbd, 5'b11110); end
`endif
    send_frame(8'h15);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL goodpar_Q got=%b want=%b", kbd, 5'b11110); end
    send_frame(8'hF0);
    send_frame(8'h15);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL release_Q got=%b want=%b", kbd, 5'b11111); end
  endtask

  task automatic test_timeout;
    int s0;
    s0 = strobes;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (TO + 200) @(negedge clk);
    set_rows(8'h7F);
    send_frame(8'h29);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL timeout_space got=%b want=%b", kbd, 5'b11110); end
    n_cmp++; if (last_sc !== 8'h29 || strobes !== s0 + 1) begin n_fail++; $display("FAIL timeout_sc got=%h/%0d want=%h/%0d", last_sc, strobes - s0, 8'h29, 1); end
    send_frame(8'hF0);
    send_frame(8'h29);
  endtask

  task automatic test_bat;
    send_frame(8'h16);
    send_frame(8'h45);
    set_rows(8'h00);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL bat_before got=%b want=%b", kbd, 5'b11110); end
    send_frame(8'hAA);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL bat_clear got=%b want=%b", kbd, 5'b11111); end
    n_cmp++; if (last_sc !== 8'hAA) begin n_fail++; $display("FAIL bat_sc got=%h want=%h", last_sc, 8'hAA); end
  endtask

  task automatic test_extended;
    send_frame(8'hE0);
    send_frame(8'h75);
    set_rows(8'hFE);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL up_caps got=%b want=%b", kbd, 5'b11110); end
    set_rows(8'hEF);
    n_cmp++; if (kbd !== 5'b10111) begin n_fail++; $display("FAIL up_seven got=%b want=%b", kbd, 5'b10111); end
    set_rows(8'hEE);
    n_cmp++; if (kbd !== 5'b10110) begin n_fail++; $display("FAIL up_both got=%b want=%b", kbd, 5'b10110); end
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL up_release got=%b want=%b", kbd, 5'b11111); end
  endtask

  task automatic test_pause_skip;
    int s0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'h2B, 8'h34, 8'h1D};
    s0 = strobes;
    for (int i = 0; i < 8; i++) send_frame(seq[i]);
    set_rows(8'h00);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL skip_kbd got=%b want=%b", kbd, 5'b11111); end
    n_cmp++; if (strobes !== s0 + 8) begin n_fail++; $display("FAIL skip_strobes got=%0d want=%0d", strobes - s0, 8); end
    set_rows(8'hFD);
    send_frame(8'h1C);
    n_cmp++; if (kbd !== 5'b11110) begin n_fail++; $display("FAIL after_skip got=%b want=%b", kbd, 5'b11110); end
    send_frame(8'hF0);
    send_frame(8'h1C);
  endtask

  task automatic test_glitch;
    set_rows(8'hFE);
    send_frame(8'h1A, 1'b0, 4);
    n_cmp++; if (kbd !== 5'b11101) begin n_fail++; $display("FAIL glitch_Z got=%b want=%b", kbd, 5'b11101); end
    n_cmp++; if (last_sc !== 8'h1A) begin n_fail++; $display("FAIL glitch_sc got=%h want=%h", last_sc, 8'h1A); end
    send_frame(8'hF0);
    send_frame(8'h1A, 1'b0, 2);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL glitch_release got=%b want=%b", kbd, 5'b11111); end
  endtask

  task automatic test_reset_midframe;
    set_rows(8'hFD);
    send_frame(8'h1C);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (kbd !== 5'b11111) begin n_fail++; $display("FAIL midreset_clear got=%b want=%b", kbd, 5'b11111); end
    set_rows(8'hFE);
    send_frame(8'h2A);
    n_cmp++; if (kbd !== 5'b01111) begin n_fail++; $display("FAIL midreset_V got=%b want=%b", kbd, 5'b01111); end
    n_cmp++; if (last_sc !== 8'h2A) begin n_fail++; $display("FAIL midreset_sc got=%h want=%h", last_sc, 8'h2A); end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_backspace;
    test_parity;
    test_timeout;
    test_bat;
    test_extended;
    test_pause_skip;
    test_glitch;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
